// File: rtl/lcd_text_buffer.sv
// Purpose: 32-char frame buffer that feeds the LCD controller: HD44780 init once, then endless refresh.
// Latency: per item 1 LOAD + 1 START + controller handshake time + DLY_CYCLES settling clocks.
// Backpressure: waits indefinitely on iLCD_Done; host writes are never stalled.
module lcd_text_buffer #(
    parameter int DLY_CYCLES = 262142
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iWR,
    input  logic [4:0] iADDR,
    input  logic [7:0] iCHAR,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_Start,
    input  logic       iLCD_Done,
    output logic       oInitDone,
    output logic       oFrameDone
);

    localparam int CW = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DLY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_DELAY   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    char_buf [32];
    logic [5:0]    item_idx;
    logic [CW-1:0] dly_cnt;
    logic          dly_last;

    logic [4:0]    rd_addr;
    logic [7:0]    item_dat;
    logic          item_rs;

    logic          do_load;
    logic          do_start;
    logic          do_xfer_end;
    logic          do_advance;

    assign dly_last = (dly_cnt == CNT_LAST);

    // Host-side character buffer; a read in LOAD sees the pre-write value.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < 32; i++) begin
                char_buf[i] <= 8'h20;
            end
        end else if (iWR) begin
            char_buf[iADDR] <= iCHAR;
        end
    end

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; WAIT_LO ignores the stale done level left from the previous transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    state_nxt = S_START;
            S_START:   state_nxt = S_WAIT_LO;
            S_WAIT_LO: if (!iLCD_Done) state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (iLCD_Done)  state_nxt = S_DELAY;
            S_DELAY:   if (dly_last)   state_nxt = S_LOAD;
            default:   state_nxt = S_LOAD;
        endcase
    end

    // Output/control decode of the current state.
    always_comb begin
        do_load     = (state == S_LOAD);
        do_start    = (state == S_START);
        do_xfer_end = (state == S_WAIT_HI) && iLCD_Done;
        do_advance  = (state == S_DELAY) && dly_last;
    end

    // Item decode: frame items 1-16 map to cells 0-15, items 18-33 to cells 16-31 (mod-32 arithmetic).
    always_comb begin
        rd_addr  = (item_idx < 6'd17) ? (item_idx[4:0] - 5'd1) : (item_idx[4:0] - 5'd2);
        item_rs  = 1'b0;
        item_dat = 8'h00;
        if (!oInitDone) begin
            case (item_idx)
                6'd0:    item_dat = 8'h38;
                6'd1:    item_dat = 8'h0C;
                6'd2:    item_dat = 8'h01;
                6'd3:    item_dat = 8'h06;
                default: item_dat = 8'h80;
            endcase
        end else if (item_idx == 6'd0) begin
            item_dat = 8'h80;
        end else if (item_idx == 6'd17) begin
            item_dat = 8'hC0;
        end else begin
            item_rs  = 1'b1;
            item_dat = char_buf[rd_addr];
        end
    end

    // Datapath: byte/RS latched only in LOAD so they stay frozen through START..DELAY.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oLCD_DATA  <= 8'h00;
            oLCD_RS    <= 1'b0;
            oLCD_Start <= 1'b0;
            oInitDone  <= 1'b0;
            oFrameDone <= 1'b0;
            item_idx   <= 6'd0;
            dly_cnt    <= '0;
        end else begin
            oFrameDone <= 1'b0;
            if (do_load) begin
                oLCD_DATA <= item_dat;
                oLCD_RS   <= item_rs;
            end
            if (do_start) begin
                oLCD_Start <= 1'b1;
            end
            if (do_xfer_end) begin
                oLCD_Start <= 1'b0;
                dly_cnt    <= '0;
            end
            if (state == S_DELAY && !dly_last) begin
                dly_cnt <= dly_cnt + CW'(1);
            end
            if (do_advance) begin
                if (!oInitDone) begin
                    if (item_idx == 6'd4) begin
                        oInitDone <= 1'b1;
                        item_idx  <= 6'd0;
                    end else begin
                        item_idx <= item_idx + 6'd1;
                    end
                end else if (item_idx == 6'd33) begin
                    item_idx   <= 6'd0;
                    oFrameDone <= 1'b1;
                end else begin
                    item_idx <= item_idx + 6'd1;
                end
            end
        end
    end

endmodule
